// File: rtl/fetch_prefetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, EX redirect and decode handoff.
// master = fetch unit side, slave = memory/EX/decode side.
interface fetch_prefetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_instr;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_pc_plus4;

  modport master (
    output imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc, if_pc_plus4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// RV32I fetch front end: PC owner, credit-limited imem requests, DEPTH-entry prefetch queue.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input logic               clk,
  input logic               reset,
  fetch_prefetch_if.master  bus
);
  localparam int              AW      = $clog2(DEPTH);
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t [DEPTH-1:0] q_mem;
  entry_t             head;
  logic [XLEN-1:0]    pc_q, resp_pc_q, tgt;
  logic [AW-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]      count, inflight, inflight_nxt, drop_cnt;
  logic               req_fire, rsp_live, rsp_drop, q_empty, push, pop, if_v;

  // Credits cover both buffered words and outstanding requests, so the queue cannot overflow.
  assign bus.imem_req_valid = !reset && (({1'b0, count} + {1'b0, inflight}) < DEPTH_W);
  assign bus.imem_addr      = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp_drop           = bus.imem_rsp_valid && (drop_cnt != '0);
  assign rsp_live           = bus.imem_rsp_valid && (drop_cnt == '0) && !bus.redirect_valid;
  assign q_empty            = (count == '0);
  assign inflight_nxt       = inflight + CW'(req_fire) - CW'(bus.imem_rsp_valid);
  assign tgt                = bus.redirect_pc & ~XLEN'(3);

  always_comb begin
    head = q_mem[rd_ptr];
    if_v = !q_empty;
    pop  = !q_empty && bus.if_ready;
    push = rsp_live;
`ifdef FETCH_BYPASS_EN
    // Empty queue: hand the live response to decode this cycle; enqueue only if decode stalls.
    if (q_empty && rsp_live) begin
      head = '{instr: bus.imem_rsp_data, pc: resp_pc_q};
      if_v = 1'b1;
      push = !bus.if_ready;
    end
`endif
  end

  assign bus.if_valid    = if_v;
  assign bus.if_instr    = if_v ? head.instr : '0;
  assign bus.if_pc       = if_v ? head.pc : '0;
  assign bus.if_pc_plus4 = if_v ? head.pc + XLEN'(4) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      inflight  <= '0;
      drop_cnt  <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (bus.redirect_valid) begin
        // Everything still outstanding, including a request accepted now, belongs to the old path.
        pc_q      <= tgt;
        resp_pc_q <= tgt;
        drop_cnt  <= inflight_nxt;
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
      end else begin
        if (req_fire) pc_q <= pc_q + XLEN'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
        if (rsp_live) resp_pc_q <= resp_pc_q + XLEN'(4);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !bus.redirect_valid && push)
      q_mem[wr_ptr] <= '{instr: bus.imem_rsp_data, pc: resp_pc_q};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (reset || bus.redirect_valid)
                                  !(push && (count == FULL) && !pop));
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed scenarios plus a randomized run
// against a queue-based model of the fetch stream.
module tb_fetch_prefetch_unit;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_prefetch_if #(.XLEN(XLEN)) bus();
  fetch_prefetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  // Outstanding requests in issue order; stale = issued on a path that was later redirected away.
  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  req_t        outst[$];
  logic [31:0] fq[$];
  logic [31:0] exp_req_addr = RESET_PC;
  int          cyc = 0;
  int          lat_lo = 1, lat_hi = 1;
  bit          e_req_valid, e_if_valid, m_fire, m_live, m_pop;
  logic [31:0] e_if_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00500093;
    if (a == 32'h4) return 32'h00A00113;
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  // Drive one cycle's inputs (memory returns the oldest request once it is due), then form expectations.
  task automatic drive(input bit rdy, input bit ifr, input bit rv, input logic [31:0] rpc);
    bus.imem_req_ready = rdy;
    bus.if_ready       = ifr;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (!reset && outst.size() > 0 && outst[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(outst[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = $urandom;
    end
    #1;
    e_req_valid = !reset && (fq.size() + outst.size() < DEPTH);
    m_live      = bus.imem_rsp_valid && outst.size() > 0 && !outst[0].stale && !rv;
    e_if_valid  = fq.size() > 0 || (BYP && m_live);
    e_if_pc     = fq.size() > 0 ? fq[0] : (m_live ? outst[0].addr : 32'h0);
    m_fire      = bus.imem_req_valid && rdy;
    m_pop       = e_if_valid && ifr;
  endtask

  task automatic advance();
    bit          rsp_now = bus.imem_rsp_valid;
    bit          rv      = bus.redirect_valid;
    logic [31:0] rpc     = bus.redirect_pc;
    bit          byp_used;
    req_t        o;
    @(posedge clk);
    if (reset) begin
      outst.delete();
      fq.delete();
      exp_req_addr = RESET_PC;
    end else begin
      byp_used = m_pop && fq.size() == 0;
      if (m_pop && fq.size() > 0) void'(fq.pop_front());
      if (rsp_now) begin
        o = outst.pop_front();
        if (m_live && !byp_used) fq.push_back(o.addr);
      end
      if (m_fire) begin
        outst.push_back('{exp_req_addr, cyc + int'($urandom_range(lat_hi, lat_lo)), 1'b0});
        exp_req_addr += 32'h4;
      end
      if (rv) begin
        fq.delete();
        foreach (outst[i]) outst[i].stale = 1'b1;
        exp_req_addr = rpc & ~32'h3;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'h0); advance();
    drive(1'b0, 1'b1, 1'b0, 32'h0); advance();
    reset = 1'b0;
    lat_lo = 1; lat_hi = 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.imem_req_valid); end
    advance();
    drive(1'b1, 1'b1, 1'b0, 32'h0); advance();
    reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b want 0", bus.if_valid); end
    checks++; if (bus.if_instr !== 32'h0) begin errors++; $display("FAIL reset_if_instr: got %h want 0", bus.if_instr); end
    checks++; if (bus.if_pc !== 32'h0) begin errors++; $display("FAIL reset_if_pc: got %h want 0", bus.if_pc); end
    checks++; if (bus.if_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_if_pc_plus4: got %h want 0", bus.if_pc_plus4); end
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_imem_addr: got %h want %h", bus.imem_addr, RESET_PC); end
    checks++; if (bus.imem_req_valid !== 1'b1) begin errors++; $display("FAIL reset_first_req: got %b want 1", bus.imem_req_valid); end
    advance();
  endtask

  task automatic test_basic_stream();
    logic [31:0] fa[4], hp[4], hi[4], hp4[4];
    int nf = 0, nh = 0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (m_fire && nf < 4) begin fa[nf] = bus.imem_addr; nf++; end
      if (bus.if_valid && nh < 4) begin hp[nh] = bus.if_pc; hi[nh] = bus.if_instr; hp4[nh] = bus.if_pc_plus4; nh++; end
      advance();
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (fa[k] !== 32'(4*k)) begin errors++; $display("FAIL basic_addr%0d: got %h want %h", k, fa[k], 32'(4*k)); end
      checks++; if (hp[k] !== 32'(4*k)) begin errors++; $display("FAIL basic_pc%0d: got %h want %h", k, hp[k], 32'(4*k)); end
      checks++; if (hp4[k] !== 32'(4*k+4)) begin errors++; $display("FAIL basic_pc4_%0d: got %h want %h", k, hp4[k], 32'(4*k+4)); end
    end
    checks++; if (hi[0] !== 32'h00500093) begin errors++; $display("FAIL basic_instr0: got %h want 00500093", hi[0]); end
    checks++; if (hi[1] !== 32'h00A00113) begin errors++; $display("FAIL basic_instr1: got %h want 00a00113", hi[1]); end
  endtask

  task automatic test_stall();
    logic [31:0] hp[4], hi[4];
    int nf = 0, nh = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h0);
      if (m_fire) nf++;
      if (i >= 2) begin
        checks++; if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0) begin errors++; $display("FAIL stall_head c%0d: got v=%b pc=%h want v=1 pc=0", i, bus.if_valid, bus.if_pc); end
      end
      advance();
    end
    checks++; if (nf !== 2) begin errors++; $display("FAIL stall_req_count: got %0d want 2", nf); end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (bus.if_valid && nh < 4) begin hp[nh] = bus.if_pc; hi[nh] = bus.if_instr; nh++; end
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      checks++; if (hp[k] !== 32'(4*k) || hi[k] !== mem_word(32'(4*k))) begin errors++; $display("FAIL stall_release%0d: got pc=%h instr=%h want pc=%h", k, hp[k], hi[k], 32'(4*k)); end
    end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    logic [31:0] ff, hp, hi;
    bit gf = 1'b0, gh = 1'b0;
    do_reset();
    for (int i = 0; i < 12 && !found; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (m_fire && bus.imem_addr == 32'h8) begin
        drive(1'b1, 1'b1, 1'b1, 32'h100);
        found = 1'b1;
      end
      advance();
      if (i == 0) begin lat_lo = 6; lat_hi = 6; end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL redir_setup: no fire to 0x8 within budget"); end
    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (i == 0) begin
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr_hold: got %h want 00000100", bus.imem_addr); end
      end
      if (m_fire && !gf) begin ff = bus.imem_addr; gf = 1'b1; end
      if (bus.if_valid && !gh) begin hp = bus.if_pc; hi = bus.if_instr; gh = 1'b1; end
      advance();
    end
    checks++; if (ff !== 32'h100) begin errors++; $display("FAIL redir_next_addr: got %h want 00000100", ff); end
    checks++; if (hp !== 32'h100) begin errors++; $display("FAIL redir_next_pc: got %h want 00000100", hp); end
    checks++; if (hi !== mem_word(32'h100)) begin errors++; $display("FAIL redir_next_instr: got %h want %h", hi, mem_word(32'h100)); end
  endtask

  task automatic test_unaligned();
    logic [31:0] ff, hp;
    bit gf = 1'b0, gh = 1'b0;
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 32'h0); advance();
    drive(1'b1, 1'b1, 1'b1, 32'h103); advance();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (m_fire && !gf) begin ff = bus.imem_addr; gf = 1'b1; end
      if (bus.if_valid && !gh) begin hp = bus.if_pc; gh = 1'b1; end
      advance();
    end
    checks++; if (ff !== 32'h100) begin errors++; $display("FAIL unaligned_addr: got %h want 00000100", ff); end
    checks++; if (hp !== 32'h100) begin errors++; $display("FAIL unaligned_pc: got %h want 00000100", hp); end
  endtask

  task automatic test_wrap();
    logic [31:0] fa[2], hp[2], hp4[2];
    int nf = 0, nh = 0;
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC); advance();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (m_fire && nf < 2) begin fa[nf] = bus.imem_addr; nf++; end
      if (bus.if_valid && nh < 2) begin hp[nh] = bus.if_pc; hp4[nh] = bus.if_pc_plus4; nh++; end
      advance();
    end
    checks++; if (fa[0] !== 32'hFFFF_FFFC || fa[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h,%h want fffffffc,00000000", fa[0], fa[1]); end
    checks++; if (hp[0] !== 32'hFFFF_FFFC || hp4[0] !== 32'h0) begin errors++; $display("FAIL wrap_pc0: got pc=%h p4=%h want fffffffc/0", hp[0], hp4[0]); end
    checks++; if (hp[1] !== 32'h0 || hp4[1] !== 32'h4) begin errors++; $display("FAIL wrap_pc1: got pc=%h p4=%h want 0/4", hp[1], hp4[1]); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hp, hi;
    bit gh = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) begin drive(1'b1, 1'b0, 1'b0, 32'h0); advance(); end
    reset = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    checks++; if (bus.if_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_full: got %b want 1", bus.if_valid); end
    checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_req_valid: got %b want 0", bus.imem_req_valid); end
    advance();
    reset = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 32'h0);
    checks++; if (bus.if_valid !== 1'b0 || bus.if_instr !== 32'h0 || bus.if_pc !== 32'h0 || bus.if_pc_plus4 !== 32'h0)
      begin errors++; $display("FAIL rstmid_outputs: got v=%b i=%h pc=%h p4=%h want all 0", bus.if_valid, bus.if_instr, bus.if_pc, bus.if_pc_plus4); end
    checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL rstmid_addr: got %h want %h", bus.imem_addr, RESET_PC); end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) drive(1'b1, 1'b1, 1'b0, 32'h0);
      if (bus.if_valid && !gh) begin hp = bus.if_pc; hi = bus.if_instr; gh = 1'b1; end
      advance();
    end
    checks++; if (hp !== RESET_PC || hi !== mem_word(RESET_PC)) begin errors++; $display("FAIL rstmid_restart: got pc=%h instr=%h want %h", hp, hi, RESET_PC); end
  endtask

  task automatic test_random();
    int byp_hits = 0, handoffs = 0;
    bit rdy, ifr, rv;
    logic [31:0] rpc;
    do_reset();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1000; i++) begin
      rdy = $urandom_range(0, 99) < 70;
      ifr = $urandom_range(0, 99) < 60;
      rv  = $urandom_range(0, 99) < 3;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : ($urandom & 32'h0000_FFFF);
      drive(rdy, ifr, rv, rpc);
      checks++; if (bus.imem_req_valid !== e_req_valid) begin errors++; $display("FAIL rand_req_valid c%0d: got %b want %b", i, bus.imem_req_valid, e_req_valid); end
      if (m_fire) begin
        checks++; if (bus.imem_addr !== exp_req_addr) begin errors++; $display("FAIL rand_addr c%0d: got %h want %h", i, bus.imem_addr, exp_req_addr); end
      end
      checks++; if (bus.if_valid !== e_if_valid) begin errors++; $display("FAIL rand_if_valid c%0d: got %b want %b", i, bus.if_valid, e_if_valid); end
      if (e_if_valid) begin
        checks++; if (bus.if_pc !== e_if_pc || bus.if_instr !== mem_word(e_if_pc) || bus.if_pc_plus4 !== e_if_pc + 32'h4)
          begin errors++; $display("FAIL rand_head c%0d: got pc=%h i=%h p4=%h want pc=%h", i, bus.if_pc, bus.if_instr, bus.if_pc_plus4, e_if_pc); end
        if (fq.size() == 0) byp_hits++;
      end
      if (m_pop) handoffs++;
      advance();
    end
    checks++; if (handoffs < 100) begin errors++; $display("FAIL rand_throughput: got %0d handoffs want >=100", handoffs); end
    checks++; if ((byp_hits > 0) !== BYP) begin errors++; $display("FAIL rand_bypass_seen: got %0d hits want present=%b", byp_hits, BYP); end
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_stall();
    test_redirect();
    test_unaligned();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
